// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decodes the RISC-V immediate of an instruction at push time
// and queues it, together with its ImmSrc, in a 2-entry FIFO.
// Optional feature macro: IMM_GEN_ERR_EN adds the 'err' output, which flags
// an illegal ImmSrc for the head entry.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int TYPE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TYPE_W-1:0] ImmSrc,
  input  logic [24:0]       data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef IMM_GEN_ERR_EN
  output logic              err,
`endif
  output logic [XLEN-1:0]   imm,
  output logic [TYPE_W-1:0] imm_type
);

  // data[k] holds instr[k+7]; the field slices below use that offset.
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic            push, pop;

  logic [1:0]                   count_q, count_d;
  logic                         wr_ptr_q, wr_ptr_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic [1:0][XLEN-1:0]         mem_imm_q, mem_imm_d;
  logic [1:0][TYPE_W-1:0]       mem_type_q, mem_type_d;

  // Immediate decode; every format is built as 32 bits, then sign-extended.
  // Z has bit 31 clear, so the sign extension leaves it zero-extended.
  always_comb begin
    imm32 = '0;
    case (ImmSrc)
      TYPE_W'(0): imm32 = {{20{data[24]}}, data[24:13]};
      TYPE_W'(1): imm32 = {{20{data[24]}}, data[24:18], data[4:0]};
      TYPE_W'(2): imm32 = {{12{data[24]}}, data[12:5], data[13], data[23:14], 1'b0};
      TYPE_W'(3): imm32 = {{20{data[24]}}, data[0], data[23:18], data[4:1], 1'b0};
      TYPE_W'(4): imm32 = {data[24:5], 12'b0};
      TYPE_W'(5): imm32 = {27'b0, data[12:8]};
      default:    imm32 = '0;
    endcase
    imm_ext = XLEN'($signed(imm32));
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // FIFO next state; flush discards everything, including a same-cycle push.
  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_imm_d  = mem_imm_q;
    mem_type_d = mem_type_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        mem_imm_d[wr_ptr_q]  = imm_ext;
        mem_type_d[wr_ptr_q] = ImmSrc;
        wr_ptr_d             = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  // FIFO state registers; reset also clears storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      mem_imm_q  <= '0;
      mem_type_q <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_imm_q  <= mem_imm_d;
      mem_type_q <= mem_type_d;
    end
  end

  // Head entry presented; forced to zero when empty.
  always_comb begin
    imm      = '0;
    imm_type = '0;
    if (out_valid) begin
      imm      = mem_imm_q[rd_ptr_q];
      imm_type = mem_type_q[rd_ptr_q];
    end
  end

`ifdef IMM_GEN_ERR_EN
  logic [1:0] mem_err_q, mem_err_d;
  logic       push_err;

  assign push_err = (ImmSrc > TYPE_W'(5));

  // Per-entry illegal-type flag, written alongside the immediate.
  always_comb begin
    mem_err_d = mem_err_q;
    if (!flush && push) mem_err_d[wr_ptr_q] = push_err;
  end

  // Error flag storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_err_q <= '0;
    else        mem_err_q <= mem_err_d;
  end

  // Head entry error flag; zero when empty.
  always_comb begin
    err = 1'b0;
    if (out_valid) err = mem_err_q[rd_ptr_q];
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and
// are compared to a queue-based reference model built from instruction fields.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [2:0]  ImmSrc;
  logic [24:0] data;
  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  type32, type64;
`ifdef IMM_GEN_ERR_EN
  logic        err32, err64;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    longint     imm;
    logic [2:0] typ;
  } ent_t;
  ent_t model_q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TYPE_W(3)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .ImmSrc(ImmSrc), .data(data),
    .out_valid(out_valid32), .out_ready(out_ready),
`ifdef IMM_GEN_ERR_EN
    .err(err32),
`endif
    .imm(imm32), .imm_type(type32));

  imm_gen_pipe #(.XLEN(64), .TYPE_W(3)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .ImmSrc(ImmSrc), .data(data),
    .out_valid(out_valid64), .out_ready(out_ready),
`ifdef IMM_GEN_ERR_EN
    .err(err64),
`endif
    .imm(imm64), .imm_type(type64));

  // Reference immediate from the architectural field definitions.
  function automatic longint ref_imm(input logic [31:0] ins, input logic [2:0] src);
    longint s;
    longint sgn;
    s   = longint'($signed(ins));
    sgn = ins[31] ? 64'sd1 : 64'sd0;
    case (src)
      3'd0: return s >>> 20;
      3'd1: return ((s >>> 25) * 32) + longint'(ins[11:7]);
      3'd2: return -sgn * (64'sd1 << 20) + longint'(ins[19:12]) * 4096
                   + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      3'd3: return -sgn * 4096 + longint'(ins[7]) * 2048
                   + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      3'd4: return s & ~longint'(4095);
      3'd5: return longint'(ins[19:15]);
      default: return 0;
    endcase
  endfunction

  // Drive one cycle, clock it, and advance the model; leaves time at posedge+1.
  task automatic step(input bit v, input logic [2:0] src, input logic [31:0] ins,
                      input bit ordy, input bit fl);
    bit   do_push, do_pop;
    ent_t e;
    in_valid  = v;
    ImmSrc    = src;
    data      = ins[31:7];
    out_ready = ordy;
    flush     = fl;
    do_push   = v && (model_q.size() < 2);
    do_pop    = (model_q.size() > 0) && ordy;
    e.imm     = ref_imm(ins, src);
    e.typ     = src;
    @(posedge clk);
    #1;
    if (fl) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ImmSrc = 3'd0; data = '0;
    #12;
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0)
      begin errors++; $display("FAIL reset_out_valid got=%b/%b exp=0", out_valid32, out_valid64); end
    checks++;
    if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1)
      begin errors++; $display("FAIL reset_in_ready got=%b/%b exp=1", in_ready32, in_ready64); end
    checks++;
    if (imm32 !== 32'h0 || imm64 !== 64'h0 || type32 !== 3'd0 || type64 !== 3'd0)
      begin errors++; $display("FAIL reset_imm got=%h/%h t=%h exp=0", imm32, imm64, type32); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_q.delete();
  endtask

  task automatic test_i_type;
    step(1, 3'd0, 32'hFFF00093, 1, 0);
    checks++;
    if (out_valid32 !== 1'b1 || imm32 !== 32'hFFFFFFFF)
      begin errors++; $display("FAIL i_imm32 got=%b/%h exp=1/ffffffff", out_valid32, imm32); end
    checks++;
    if (imm64 !== 64'hFFFFFFFFFFFFFFFF)
      begin errors++; $display("FAIL i_imm64 got=%h exp=ffffffffffffffff", imm64); end
    step(0, 3'd0, 32'h0, 1, 0);
    checks++;
    if (out_valid32 !== 1'b0 || imm32 !== 32'h0 || imm64 !== 64'h0 || type32 !== 3'd0)
      begin errors++; $display("FAIL empty_zero got=%b/%h/%h exp=0", out_valid32, imm32, imm64); end
  endtask

  task automatic test_u_type;
    step(1, 3'd4, 32'h123450B7, 0, 0);
    checks++;
    if (imm32 !== 32'h12345000 || imm64 !== 64'h12345000 || type32 !== 3'd4)
      begin errors++; $display("FAIL u_pos got=%h/%h exp=12345000", imm32, imm64); end
    step(1, 3'd4, 32'h800000B7, 1, 0);
    checks++;
    if (imm64 !== 64'hFFFFFFFF80000000 || imm32 !== 32'h80000000)
      begin errors++; $display("FAIL u_neg got=%h/%h exp=ffffffff80000000", imm64, imm32); end
    step(0, 3'd0, 32'h0, 1, 0);
  endtask

  task automatic test_b_hold_full;
    step(1, 3'd3, 32'hFE000EE3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'd0, 32'h0, 0, 0);
      checks++;
      if (out_valid32 !== 1'b1 || imm32 !== 32'hFFFFFFFC || imm64 !== 64'hFFFFFFFFFFFFFFFC || type32 !== 3'd3)
        begin errors++; $display("FAIL b_hold cyc=%0d got=%h/%h t=%0d exp=fffffffc", i, imm32, imm64, type32); end
    end
    step(1, 3'd0, 32'hFFF00093, 0, 0);
    checks++;
    if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0 || imm32 !== 32'hFFFFFFFC)
      begin errors++; $display("FAIL full_ready got=%b/%h exp=0/fffffffc", in_ready32, imm32); end
    step(1, 3'd5, 32'h0002D073, 0, 0);
    checks++;
    if (in_ready32 !== 1'b0 || type32 !== 3'd3)
      begin errors++; $display("FAIL full_refuse got=%b t=%0d exp=0/3", in_ready32, type32); end
    step(1, 3'd5, 32'h0002D073, 1, 0);
    checks++;
    if (in_ready32 !== 1'b1 || imm32 !== 32'hFFFFFFFF || type32 !== 3'd0)
      begin errors++; $display("FAIL full_pop_no_push got=%b/%h t=%0d exp=1/ffffffff/0", in_ready32, imm32, type32); end
    step(1, 3'd5, 32'h0002D073, 0, 0);
    checks++;
    if (in_ready32 !== 1'b0)
      begin errors++; $display("FAIL refill got=%b exp=0", in_ready32); end
    step(0, 3'd0, 32'h0, 1, 0);
    checks++;
    if (imm32 !== 32'd5 || imm64 !== 64'd5 || type32 !== 3'd5)
      begin errors++; $display("FAIL z_imm got=%h/%h t=%0d exp=5/5", imm32, imm64, type32); end
    step(0, 3'd0, 32'h0, 1, 0);
  endtask

  task automatic test_flush;
    step(1, 3'd0, 32'h00100093, 0, 0);
    step(1, 3'd1, 32'hFE112E23, 0, 0);
    step(1, 3'd0, 32'h7FF00093, 1, 1);
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 || imm32 !== 32'h0)
      begin errors++; $display("FAIL flush got=%b/%b/%h exp=0/1/0", out_valid32, in_ready32, imm32); end
    step(0, 3'd0, 32'h0, 1, 0);
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0)
      begin errors++; $display("FAIL flush_lost got=%b exp=0", out_valid32); end
  endtask

  task automatic test_illegal_async_reset;
    step(1, 3'd7, 32'hFFFFFFFF, 0, 0);
    checks++;
    if (out_valid32 !== 1'b1 || imm32 !== 32'h0 || imm64 !== 64'h0 || type32 !== 3'd7)
      begin errors++; $display("FAIL illegal got=%b/%h/%h t=%0d exp=1/0/0/7", out_valid32, imm32, imm64, type32); end
`ifdef IMM_GEN_ERR_EN
    checks++;
    if (err32 !== 1'b1 || err64 !== 1'b1)
      begin errors++; $display("FAIL err_flag got=%b/%b exp=1", err32, err64); end
`endif
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 || imm32 !== 32'h0 || type32 !== 3'd0)
      begin errors++; $display("FAIL async_rst got=%b/%b/%h exp=0/1/0", out_valid32, in_ready32, imm32); end
    #1 rst_n = 1'b1;
    model_q.delete();
    step(0, 3'd0, 32'h0, 1, 0);
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0)
      begin errors++; $display("FAIL post_rst got=%b exp=0", out_valid32); end
  endtask

  task automatic test_random;
    longint     e_imm;
    logic [2:0] e_typ;
    bit         e_vld, e_rdy;
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      e_vld = model_q.size() != 0;
      e_rdy = model_q.size() < 2;
      e_imm = e_vld ? model_q[0].imm : 64'd0;
      e_typ = e_vld ? model_q[0].typ : 3'd0;
      checks++;
      if (out_valid32 !== e_vld || out_valid64 !== e_vld || in_ready32 !== e_rdy || in_ready64 !== e_rdy)
        begin errors++; $display("FAIL rnd_hs n=%0d got=%b%b exp=%b%b", n, out_valid32, in_ready32, e_vld, e_rdy); end
      checks++;
      if (imm32 !== 32'(e_imm) || imm64 !== 64'(e_imm) || type32 !== e_typ || type64 !== e_typ)
        begin errors++; $display("FAIL rnd_imm n=%0d got=%h/%h t=%0d exp=%h t=%0d", n, imm32, imm64, type32, e_imm, e_typ); end
`ifdef IMM_GEN_ERR_EN
      checks++;
      if (err32 !== (e_vld && e_typ > 3'd5) || err64 !== (e_vld && e_typ > 3'd5))
        begin errors++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, err32, e_vld && e_typ > 3'd5); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_u_type();
    test_b_hold_full();
    test_flush();
    test_illegal_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
